ecg_stream_ctrl: RTL

- Feeds the ECG analysis core (`alg_core`) from the UART byte stream.
- Reassembles self-framed two-byte 11-bit samples and buffers them in a small FIFO.
- Releases one sample per sample period (clock-divider tick) with `ce` / `data_valid` sequencing.
- Sits between the UART receiver and `alg_core` in the Basys 3 top level; reports sticky overflow, underrun and framing errors.

---
 rtl/ecg_stream_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/ecg_stream_ctrl.sv
// rtl/ecg_stream_ctrl.sv - UART byte stream to alg_core sample feeder
// Reassembles two-byte 11-bit samples, buffers them and releases one per sample period.
module ecg_stream_ctrl #(
  parameter int CLK_DIV    = 277778,
  parameter int FIFO_DEPTH = 16,
  parameter int PRIME_LVL  = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          run,
  input  logic                          clr_err,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [10:0]                   ecg_value,
  output logic                          data_valid,
  output logic                          ce,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underrun,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            armed;
  logic [6:0]      low_byte;
  logic [10:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  logic tick, fifo_empty, fifo_full, hi_byte, lo_byte;
  logic do_pop, push_req, do_push;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = PRIME;
      PRIME: begin
        if (!run)                              state_nxt = IDLE;
        else if (fifo_level >= LW'(PRIME_LVL)) state_nxt = STREAM;
      end
      STREAM:  if (!run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign tick       = (state == STREAM) && (cnt == '0);
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
  assign hi_byte    = rx_valid &  rx_data[7];
  assign lo_byte    = rx_valid & ~rx_data[7];
  assign do_pop     = tick & ~fifo_empty;
  assign push_req   = hi_byte & armed;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push    = push_req & (~fifo_full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {rx_data[3:0], low_byte};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      ce         <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
      armed      <= 1'b0;
      low_byte   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ecg_value  <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underrun   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      ce    <= (state_nxt != IDLE);
      busy  <= (state_nxt != IDLE);

      if (state == STREAM && state_nxt == STREAM)
        cnt <= (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
      else
        cnt <= '0;

      if (lo_byte) begin
        armed    <= 1'b1;
        low_byte <= rx_data[6:0];
      end else if (hi_byte) begin
        armed    <= 1'b0;
      end

      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        ecg_value <= mem[rd_ptr];
      end
      data_valid <= do_pop;
      fifo_level <= fifo_level + LW'(do_push) - LW'(do_pop);

      // A new error event outranks a same-cycle clear.
      overflow  <= (push_req & fifo_full & ~do_pop) | (overflow  & ~clr_err);
      underrun  <= (tick & fifo_empty)             | (underrun  & ~clr_err);
      frame_err <= (hi_byte & ~armed)              | (frame_err & ~clr_err);
    end
  end

endmodule
